key_cmd_sequencer: RTL and testbench

KEY_CMD_SEQUENCER -- requirements
Module: key_cmd_sequencer

---
 rtl/key_cmd_sequencer_pkg.sv | 39 +++
 rtl/key_cmd_sequencer_key_stabilizer.sv | 35 +++
 rtl/key_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_key_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_sequencer_pkg.sv
// Shared opcode, FSM-state and operator-token definitions for the key command path.
package key_cmd_sequencer_pkg;

  localparam int unsigned NUM_SRC = 5;

  // The opcode value doubles as the pending-bit index of its source.
  typedef enum logic [2:0] {
    CMD_INS   = 3'd0,
    CMD_DEL   = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_EVAL  = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_EVAL_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] TOK_PLUS   = 8'hA0;
  localparam logic [7:0] TOK_MINUS  = 8'hA1;
  localparam logic [7:0] TOK_MUL    = 8'hA2;
  localparam logic [7:0] TOK_DIV    = 8'hA3;
  localparam logic [7:0] TOK_LPAREN = 8'hA4;
  localparam logic [7:0] TOK_RPAREN = 8'hA5;

  // Highest-priority pending source: eval > del > left > right > insert.
  function automatic cmd_op_e pick_cmd(input logic [NUM_SRC-1:0] pend);
    cmd_op_e op;
    op = CMD_INS;
    if (pend[CMD_EVAL])       op = CMD_EVAL;
    else if (pend[CMD_DEL])   op = CMD_DEL;
    else if (pend[CMD_LEFT])  op = CMD_LEFT;
    else if (pend[CMD_RIGHT]) op = CMD_RIGHT;
    return op;
  endfunction

endpackage

// File: rtl/key_cmd_sequencer_key_stabilizer.sv
// Per-source stability counter: accepts a press once the level has been high
// HOLD consecutive samples, then stays quiet until the level is seen low.
module key_stabilizer #(
  parameter int HOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic accept
);

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Saturating count; saturation at HOLD is what blocks re-acceptance until release.
  always_comb begin
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (!level) begin
      cnt_d = '0;
    end else if (cnt_q != HOLD_C) begin
      cnt_d  = cnt_q + 4'd1;
      accept = (cnt_q == HOLD_C - 4'd1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_cmd_sequencer.sv
// Debounces five keyboard sources, queues one press per source and issues
// them as prioritised commands over a valid/ready handshake.
module key_cmd_sequencer
  import key_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             insert,
  input  logic             del_pulse,
  input  logic             ptrLeft_pulse,
  input  logic             ptrRight_pulse,
  input  logic             eval_pulse,
  input  logic             cmd_ready,
  input  logic             eval_done,
  output logic             cmd_valid,
  output logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] cmd_data,
  output logic             busy,
  output logic             drop
);

  logic [NUM_SRC-1:0] src_level;
  logic [NUM_SRC-1:0] acc;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]   pend_data_q, pend_data_d;
  logic               drop_q, drop_d;
  state_e             state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  cmd_op_e            cmd_op_q, cmd_op_d;
  logic [WIDTH-1:0]   cmd_data_q, cmd_data_d;
  logic               busy_q, busy_d;

  assign src_level = {eval_pulse, ptrRight_pulse, ptrLeft_pulse, del_pulse, insert};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_stab
    key_stabilizer #(.HOLD(HOLD)) u_stab (
      .clock  (clock),
      .reset  (reset),
      .level  (src_level[g]),
      .accept (acc[g])
    );
  end

  // Pending bits: a press landing on the handshake edge of its own bit wins
  // over the clear; otherwise a press on an occupied bit is dropped.
  always_comb begin
    clr = '0;
    if (state_q == ST_ISSUE && cmd_ready) clr[cmd_op_q] = 1'b1;
    pend_d      = (pend_q & ~clr) | acc;
    drop_d      = |(acc & pend_q & ~clr);
    pend_data_d = pend_data_q;
    if (acc[CMD_INS] && !(pend_q[CMD_INS] && !clr[CMD_INS])) pend_data_d = dataIn;
  end

  // Command FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_data_d  = cmd_data_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          cmd_op_d    = pick_cmd(pend_q);
          cmd_data_d  = (cmd_op_d == CMD_INS) ? pend_data_q : '0;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (cmd_op_q == CMD_EVAL) begin
            busy_d  = 1'b1;
            state_d = ST_EVAL_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EVAL_WAIT: begin
        if (eval_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // All sequencer state; reset abandons any in-flight command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      pend_data_q <= '0;
      drop_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= CMD_INS;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      drop_q      <= drop_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_key_cmd_sequencer.sv
// Self-checking bench for key_cmd_sequencer: directed scenarios plus a
// randomized run compared against a behavioural model of the command flow.
module tb_key_cmd_sequencer;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic [4:0] lv = '0;   // [0]=insert [1]=del [2]=left [3]=right [4]=eval
  logic       cmd_ready = 1'b0;
  logic       eval_done = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       busy;
  logic       drop;

  int checks = 0;
  int failures = 0;

  key_cmd_sequencer #(.WIDTH(8), .HOLD(HOLD)) dut (
    .clock          (clock),
    .reset          (reset),
    .dataIn         (din),
    .insert         (lv[0]),
    .del_pulse      (lv[1]),
    .ptrLeft_pulse  (lv[2]),
    .ptrRight_pulse (lv[3]),
    .eval_pulse     (lv[4]),
    .cmd_ready      (cmd_ready),
    .eval_done      (eval_done),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .busy           (busy),
    .drop           (drop)
  );

  always #5 clock = ~clock;

  // Behavioural model: run lengths of high samples, one pending slot per key,
  // and a phase: 0 = waiting for work, 1 = offering a command, 2 = evaluator busy.
  int         run [5];
  bit         m_pend [5];
  logic [7:0] m_data = '0;
  int         m_phase = 0;
  int         m_op = 0;
  logic [7:0] m_cdata = '0;
  bit         m_drop = 0;
  int         prio [5] = '{4, 1, 2, 3, 0};

  task automatic model_edge();
    bit         acc [5];
    bit         clr [5];
    bit         old_pend [5];
    logic [7:0] old_data;
    int         old_phase;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin run[i] = 0; m_pend[i] = 0; end
      m_data = '0; m_phase = 0; m_op = 0; m_cdata = '0; m_drop = 0;
      return;
    end
    old_pend  = m_pend;
    old_data  = m_data;
    old_phase = m_phase;
    for (int i = 0; i < 5; i++) clr[i] = 0;
    if (old_phase == 1 && cmd_ready) clr[m_op] = 1;
    m_drop = 0;
    for (int i = 0; i < 5; i++) begin
      run[i] = lv[i] ? run[i] + 1 : 0;
      acc[i] = (run[i] == HOLD);
      if (acc[i] && old_pend[i] && !clr[i]) m_drop = 1;
    end
    if (acc[0] && !(old_pend[0] && !clr[0])) m_data = din;
    for (int i = 0; i < 5; i++) m_pend[i] = (old_pend[i] && !clr[i]) || acc[i];
    case (old_phase)
      0: begin
        for (int k = 4; k >= 0; k--) begin
          if (old_pend[prio[k]]) m_op = prio[k];
        end
        if (old_pend[0] || old_pend[1] || old_pend[2] || old_pend[3] || old_pend[4]) begin
          m_cdata = (m_op == 0) ? old_data : 8'h00;
          m_phase = 1;
        end
      end
      1: if (cmd_ready) m_phase = (m_op == 4) ? 2 : 0;
      default: if (eval_done) m_phase = 0;
    endcase
  endtask

  // One clock: advance model with the pre-edge inputs, then settle past the edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; lv = '0; din = '0; cmd_ready = 1'b0; eval_done = 1'b0;
    tick(); tick();
    checks++;
    if ({cmd_valid, busy, drop} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {cmd_valid, busy, drop});
    end
    checks++;
    if ({cmd_op, cmd_data} !== 11'h000) begin
      failures++; $display("FAIL reset_cmd got op=%0d data=%h exp op=0 data=00", cmd_op, cmd_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_insert();
    cmd_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int early = 0;
      din = 8'h07; lv[0] = 1'b1;
      repeat (4) begin tick(); if (cmd_valid) early++; end
      lv[0] = 1'b0; din = 8'h55;
      checks++;
      if (early != 0) begin failures++; $display("FAIL ins_early r=%0d got=%0d exp=0", r, early); end
      tick();
      checks++;
      if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd0, 8'h07}) begin
        failures++; $display("FAIL ins_cmd r=%0d got v=%b op=%0d d=%h exp v=1 op=0 d=07", r, cmd_valid, cmd_op, cmd_data);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin failures++; $display("FAIL ins_one_cycle r=%0d got=%b exp=0", r, cmd_valid); end
    end
  endtask

  task automatic test_eval_priority();
    cmd_ready = 1'b1; eval_done = 1'b0; din = 8'hA0; lv = 5'b10001;
    repeat (4) tick();
    lv = '0; din = 8'h00;
    tick();
    checks++;
    if ({cmd_valid, cmd_op} !== {1'b1, 3'd4}) begin
      failures++; $display("FAIL evpri_first got v=%b op=%0d exp v=1 op=4", cmd_valid, cmd_op);
    end
    repeat (4) begin
      tick();
      checks++;
      if ({cmd_valid, busy} !== 2'b01) begin
        failures++; $display("FAIL evpri_wait got v=%b busy=%b exp v=0 busy=1", cmd_valid, busy);
      end
    end
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    checks++;
    if ({cmd_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL evpri_done got v=%b busy=%b exp 0 0", cmd_valid, busy);
    end
    tick();
    checks++;
    if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd0, 8'hA0}) begin
      failures++; $display("FAIL evpri_ins got v=%b op=%0d d=%h exp v=1 op=0 d=a0", cmd_valid, cmd_op, cmd_data);
    end
    tick();
  endtask

  task automatic test_stall();
    int unstable = 0;
    cmd_ready = 1'b0; lv[2] = 1'b1;
    repeat (4) tick();
    lv[2] = 1'b0;
    tick();
    checks++;
    if ({cmd_valid, cmd_op} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL stall_start got v=%b op=%0d exp v=1 op=2", cmd_valid, cmd_op);
    end
    eval_done = 1'b1;   // must be ignored outside the evaluator wait
    repeat (10) begin
      tick();
      if ({cmd_valid, cmd_op, cmd_data, busy} !== {1'b1, 3'd2, 8'h00, 1'b0}) unstable++;
    end
    eval_done = 1'b0;
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if ({cmd_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL stall_consume got v=%b busy=%b exp 0 0", cmd_valid, busy);
    end
  endtask

  task automatic test_drop_in_eval();
    int drops = 0;
    int dels = 0;
    cmd_ready = 1'b1; lv[4] = 1'b1;
    repeat (4) tick();
    lv[4] = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", busy); end
    lv[1] = 1'b1; repeat (4) begin tick(); drops += int'(drop); end
    lv[1] = 1'b0; tick(); drops += int'(drop);
    lv[1] = 1'b1; repeat (4) begin tick(); drops += int'(drop); end
    lv[1] = 1'b0; tick(); drops += int'(drop);
    checks++;
    if (drops != 1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drops); end
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    repeat (6) begin tick(); if (cmd_valid && cmd_op == 3'd1) dels++; end
    checks++;
    if (dels != 1) begin failures++; $display("FAIL drop_del_cmds got=%0d exp=1", dels); end
  endtask

  task automatic test_short_and_reset();
    int events = 0;
    int vis = 0;
    cmd_ready = 1'b1; lv[1] = 1'b1;
    repeat (3) begin tick(); events += int'(cmd_valid) + int'(drop); end
    lv[1] = 1'b0;
    repeat (6) begin tick(); events += int'(cmd_valid) + int'(drop); end
    checks++;
    if (events != 0) begin failures++; $display("FAIL short_press got=%0d exp=0", events); end
    cmd_ready = 1'b0; lv[3] = 1'b1;
    repeat (5) tick();
    checks++;
    if ({cmd_valid, cmd_op} !== {1'b1, 3'd3}) begin
      failures++; $display("FAIL rst_issue got v=%b op=%0d exp v=1 op=3", cmd_valid, cmd_op);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_abandon got=%b exp=0", cmd_valid); end
    cmd_ready = 1'b1;
    repeat (4) begin tick(); vis += int'(cmd_valid); end
    checks++;
    if (vis != 0) begin failures++; $display("FAIL rst_fresh_hold got=%0d exp=0", vis); end
    tick();
    checks++;
    if ({cmd_valid, cmd_op} !== {1'b1, 3'd3}) begin
      failures++; $display("FAIL rst_reaccept got v=%b op=%0d exp v=1 op=3", cmd_valid, cmd_op);
    end
    lv[3] = 1'b0; tick(); tick();
  endtask

  task automatic test_random();
    reset = 1'b1; lv = '0; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) lv[i] = ~lv[i];
      din       = 8'($urandom);
      cmd_ready = ($urandom_range(0, 9) < 7);
      eval_done = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({cmd_valid, busy, drop} !== {m_phase == 1, m_phase == 2, m_drop}) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got v/b/d=%b exp=%b", c, {cmd_valid, busy, drop},
                 {m_phase == 1, m_phase == 2, m_drop});
      end
      if (m_phase == 1) begin
        checks++;
        if ({cmd_op, cmd_data} !== {3'(m_op), m_cdata}) begin
          failures++;
          $display("FAIL rand_cmd cyc=%0d got op=%0d d=%h exp op=%0d d=%h", c, cmd_op, cmd_data, m_op, m_cdata);
        end
      end
    end
    reset = 1'b0; eval_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_insert();
    test_eval_priority();
    test_stall();
    test_drop_in_eval();
    test_short_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
